mem_access_unit: RTL and testbench
==================================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have port clk, input, 1 bit: clock; all state updates on the rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-003 SHALL have port req_valid, input, 1 bit: the pipeline presents an access.
REQ-004 SHALL have port req_ready, output, 1 bit: the unit accepts an access this cycle.
REQ-005 SHALL have port req_wr, input, 1 bit: 1 = store, 0 = load.
REQ-006 SHALL have port req_addr, input, 32 bits: byte address.
REQ-007 SHALL have port req_wdata, input, 32 bits: store data, right-aligned.
REQ-008 SHALL have port req_length, input, 2 bits: 00 = byte, 01 = half, 10 = word, 11 = illegal.
REQ-009 SHALL have port req_sign, input, 1 bit: sign-extend load data.
REQ-010 SHALL have port resp_valid, output, 1 bit: the response is available.
REQ-011 SHALL have port resp_ready, input, 1 bit: the pipeline consumes the response.
REQ-012 SHALL have port resp_rdata, output, 32 bits: load data, extended per size and sign.
REQ-013 SHALL have port resp_err, output, 1 bit: the access was faulted and not performed.
REQ-014 SHALL have memory-side outputs mem_addr (32 bits), mem_data_in (32 bits), mem_length (2 bits), mem_sign (1 bit), mem_enable (1 bit) and mem_wr (1 bit).
REQ-015 SHALL have memory-side input mem_data_out, 32 bits, returned combinationally by the memory.

Function
REQ-016 SHALL implement the FSM states IDLE, ISSUE and RESP.
REQ-017 IDLE: req_ready=1; when req_valid=1, SHALL latch wr, addr, wdata, length and sign, then go to ISSUE, or go to RESP with a fault.
REQ-018 Fault conditions SHALL be: req_length==11; req_addr[31:16]!=0 (outside the 64 KB space); and the misalignment fault of REQ-033 when that feature is compiled in.
REQ-019 ISSUE SHALL last exactly one cycle, during which mem_enable=1, mem_wr=latched wr, and address/data/length are driven from the latches.
REQ-020 On a load, SHALL capture mem_data_out at the end of the ISSUE cycle.
REQ-021 On a store, the write SHALL take effect on the clock edge that ends the ISSUE cycle.
REQ-022 Outside ISSUE, mem_enable and mem_wr SHALL be 0.
REQ-023 mem_sign SHALL always be 0; sign/zero extension SHALL be done in this unit.
REQ-024 Extension rule: byte load extends bit 7; half load extends bit 15; word load passes all 32 bits; extension uses sign bit when req_sign=1, else zero.
REQ-025 Byte data SHALL be taken from mem_data_out[7:0] and half data from mem_data_out[15:0] (the memory returns big-endian, right-aligned data).
REQ-026 RESP: resp_valid=1, with resp_rdata and resp_err held stable until resp_ready=1; the unit SHALL then go to IDLE the next cycle.
REQ-027 Stores and faulted accesses SHALL return resp_rdata=0; faulted accesses SHALL return resp_err=1 and SHALL never assert mem_enable.
REQ-028 Latency: request accepted at edge N -> mem access in cycle N+1 -> resp_valid in cycle N+2; a faulted request gives resp_valid in cycle N+1.
REQ-029 Only one request SHALL be outstanding; req_ready=0 in ISSUE and in RESP (no same-cycle turnaround).

Reset
REQ-030 With rst=1 at an edge, SHALL go to IDLE and clear resp_valid, resp_err, resp_rdata and all latches to 0 in every state, including mid-ISSUE and mid-RESP.
REQ-031 While rst=1, req_ready=0 and mem_enable=0; the in-flight access is dropped with no response.
REQ-032 After reset, all outputs SHALL be 0 except req_ready=1 once rst falls.

Configuration
REQ-033 Macro LSU_MISALIGN_TRAP_EN defined: a half access with addr[0]=1 or a word access with addr[1:0]!=0 SHALL be faulted (resp_err=1, no memory access).
REQ-034 Macro LSU_MISALIGN_TRAP_EN undefined: misaligned accesses SHALL be issued unmodified, and only the faults in REQ-018 apply.

Verification
REQ-035 Store word 0xDEADBEEF @0x0100, then load word @0x0100 -> one-cycle mem_enable pulse with mem_wr=1, then resp_rdata=0xDEADBEEF, resp_err=0, resp_valid at N+2.
REQ-036 Memory holds 0x80 @0x0010; load byte @0x0010 with sign=1 -> 0xFFFFFF80; the same load with sign=0 -> 0x00000080.
REQ-037 Load @0x00010000 or with length=11 -> resp_err=1, resp_rdata=0, resp_valid at N+1, mem_enable never asserted.
REQ-038 Load half @0x0101 -> resp_err=1 with LSU_MISALIGN_TRAP_EN defined; with it undefined, the access is issued and resp_err=0.
REQ-039 Hold resp_ready=0 for 5 cycles -> resp_valid and resp_rdata stable and req_ready=0 throughout; assert rst during ISSUE -> mem_enable=0 that cycle, IDLE next, no response.

Source files
------------

// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if: pipeline request/response and memory-side signals of the load/store unit
interface mem_access_unit_if;
  logic        req_valid, req_ready, req_wr, req_sign;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_length;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] mem_addr, mem_data_in, mem_data_out;
  logic [1:0]  mem_length;
  logic        mem_sign, mem_enable, mem_wr;
  modport master (
    output req_valid, req_wr, req_addr, req_wdata, req_length, req_sign, resp_ready, mem_data_out,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  mem_addr, mem_data_in, mem_length, mem_sign, mem_enable, mem_wr
  );
  modport slave (
    input  req_valid, req_wr, req_addr, req_wdata, req_length, req_sign, resp_ready, mem_data_out,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output mem_addr, mem_data_in, mem_length, mem_sign, mem_enable, mem_wr
  );
endinterface

// File: rtl/mem_access_unit.sv
// mem_access_unit: single-outstanding load/store unit with fault checks and load extension.
// Define LSU_MISALIGN_TRAP_EN to fault misaligned half/word accesses.
module mem_access_unit (
  input logic              clk,
  input logic              rst,
  mem_access_unit_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
  state_t      r_state, w_next;
  logic        r_wr, r_sign, r_err;
  logic [31:0] r_addr, r_wdata, r_rdata;
  logic [1:0]  r_length;
  logic        w_misalign, w_fault, w_accept;
  logic [31:0] w_ext;
`ifdef LSU_MISALIGN_TRAP_EN
  assign w_misalign = (bus.req_length == 2'b01 && bus.req_addr[0]) ||
                      (bus.req_length == 2'b10 && |bus.req_addr[1:0]);
`else
  assign w_misalign = 1'b0;
`endif
  assign w_fault  = bus.req_length == 2'b11 || |bus.req_addr[31:16] || w_misalign;
  assign w_accept = r_state == IDLE && bus.req_valid;
  // memory returns right-aligned data; extension is done here, never by the memory
  assign w_ext = r_length == 2'b00 ? {{24{r_sign & bus.mem_data_out[7]}}, bus.mem_data_out[7:0]} :
                 r_length == 2'b01 ? {{16{r_sign & bus.mem_data_out[15]}}, bus.mem_data_out[15:0]} :
                 bus.mem_data_out;
  always_ff @(posedge clk)
    r_state <= rst ? IDLE : w_next;
  always_comb begin
    w_next = r_state;
    w_next = w_accept ? (w_fault ? RESP : ISSUE) :
             r_state == ISSUE ? RESP :
             (r_state == RESP && bus.resp_ready) ? IDLE : r_state;
    bus.req_ready   = r_state == IDLE && !rst;
    bus.mem_enable  = r_state == ISSUE && !rst;
    bus.mem_wr      = r_state == ISSUE && !rst && r_wr;
    bus.resp_valid  = r_state == RESP;
    bus.resp_rdata  = r_rdata;
    bus.resp_err    = r_err;
    bus.mem_addr    = r_addr;
    bus.mem_data_in = r_wdata;
    bus.mem_length  = r_length;
    bus.mem_sign    = 1'b0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr     <= 1'b0;
      r_sign   <= 1'b0;
      r_err    <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_length <= '0;
      r_rdata  <= '0;
    end else if (w_accept) begin
      r_wr     <= bus.req_wr;
      r_sign   <= bus.req_sign;
      r_addr   <= bus.req_addr;
      r_wdata  <= bus.req_wdata;
      r_length <= bus.req_length;
      r_err    <= w_fault;
      r_rdata  <= '0;
    end else if (r_state == ISSUE && !r_wr) begin
      r_rdata  <= w_ext;
    end
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: scoreboard bench with a big-endian byte memory model.
module tb_mem_access_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  mem_access_unit_if bus();
  mem_access_unit dut (.clk(clk), .rst(rst), .bus(bus));
  logic [7:0] mem [0:65535];
  int total = 0;
  int bad = 0;
  typedef struct {logic [31:0] d; logic e; int lat; int en; int wen;} exp_t;
  exp_t q[$];
  function automatic logic [31:0] rd(input logic [15:0] a, input logic [1:0] len);
    rd = len == 2'b00 ? {24'h0, mem[a]} :
         len == 2'b01 ? {16'h0, mem[a], mem[a + 16'd1]} :
         {mem[a], mem[a + 16'd1], mem[a + 16'd2], mem[a + 16'd3]};
  endfunction
  assign bus.mem_data_out = rd(bus.mem_addr[15:0], bus.mem_length);
  always @(posedge clk) begin
    if (bus.mem_enable && bus.mem_wr) begin
      case (bus.mem_length)
        2'b00: mem[bus.mem_addr[15:0]] <= bus.mem_data_in[7:0];
        2'b01: begin
          mem[bus.mem_addr[15:0]]         <= bus.mem_data_in[15:8];
          mem[bus.mem_addr[15:0] + 16'd1] <= bus.mem_data_in[7:0];
        end
        default: begin
          mem[bus.mem_addr[15:0]]         <= bus.mem_data_in[31:24];
          mem[bus.mem_addr[15:0] + 16'd1] <= bus.mem_data_in[23:16];
          mem[bus.mem_addr[15:0] + 16'd2] <= bus.mem_data_in[15:8];
          mem[bus.mem_addr[15:0] + 16'd3] <= bus.mem_data_in[7:0];
        end
      endcase
    end
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic drive(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [1:0] len, input logic sg);
    @(negedge clk);
    chk("req_ready_idle", {31'h0, bus.req_ready}, 32'h1);
    bus.req_valid = 1'b1; bus.req_wr = wr; bus.req_addr = addr;
    bus.req_wdata = wd; bus.req_length = len; bus.req_sign = sg;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
  endtask
  task automatic send(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                      input logic [1:0] len, input logic sg,
                      input logic [31:0] ed, input logic ee, input int hold);
    exp_t x;
    int lat, en, wen;
    q.push_back('{d: ed, e: ee, lat: ee ? 1 : 2, en: ee ? 0 : 1, wen: (!ee && wr) ? 1 : 0});
    drive(wr, addr, wd, len, sg);
    lat = 1; en = 0; wen = 0;
    while (!bus.resp_valid && lat < 10) begin
      en += int'(bus.mem_enable);
      wen += int'(bus.mem_wr);
      @(posedge clk); #1;
      lat++;
    end
    for (int i = 0; i < hold; i++) begin
      chk("hold_valid", {31'h0, bus.resp_valid}, 32'h1);
      chk("hold_rdata", bus.resp_rdata, q[0].d);
      chk("hold_ready", {31'h0, bus.req_ready}, 32'h0);
      @(posedge clk); #1;
    end
    bus.resp_ready = 1'b1;
    x = q.pop_front();
    chk("rdata", bus.resp_rdata, x.d);
    chk("err", {31'h0, bus.resp_err}, {31'h0, x.e});
    chk("latency", lat, x.lat);
    chk("mem_en_pulses", en, x.en);
    chk("mem_wr_pulses", wen, x.wen);
    @(posedge clk); #1;
    bus.resp_ready = 1'b0;
    chk("post_valid", {31'h0, bus.resp_valid}, 32'h0);
    chk("post_ready", {31'h0, bus.req_ready}, 32'h1);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end
  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'h0010] = 8'h80;
    bus.req_valid = 1'b0; bus.req_wr = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
    bus.req_length = '0; bus.req_sign = 1'b0; bus.resp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", {31'h0, bus.req_ready}, 32'h0);
    chk("rst_mem_en", {31'h0, bus.mem_enable}, 32'h0);
    chk("rst_resp_valid", {31'h0, bus.resp_valid}, 32'h0);
    @(negedge clk); rst = 1'b0; #1;
    chk("por_req_ready", {31'h0, bus.req_ready}, 32'h1);
    chk("por_rdata", bus.resp_rdata, 32'h0);
    chk("por_err", {31'h0, bus.resp_err}, 32'h0);
    chk("por_mem_addr", bus.mem_addr, 32'h0);
    chk("por_mem_din", bus.mem_data_in, 32'h0);
    chk("por_mem_ctl", {26'h0, bus.mem_length, bus.mem_sign, bus.mem_enable, bus.mem_wr}, 32'h0);
    send(1'b1, 32'h0100, 32'hDEADBEEF, 2'b10, 1'b0, 32'h0, 1'b0, 0);
    send(1'b0, 32'h0100, 32'h0, 2'b10, 1'b1, 32'hDEADBEEF, 1'b0, 5);
    send(1'b0, 32'h0010, 32'h0, 2'b00, 1'b1, 32'hFFFFFF80, 1'b0, 0);
    send(1'b0, 32'h0010, 32'h0, 2'b00, 1'b0, 32'h00000080, 1'b0, 1);
    send(1'b1, 32'h0200, 32'h1234ABCD, 2'b01, 1'b0, 32'h0, 1'b0, 0);
    send(1'b0, 32'h0200, 32'h0, 2'b01, 1'b1, 32'hFFFFABCD, 1'b0, 0);
    send(1'b0, 32'h0200, 32'h0, 2'b01, 1'b0, 32'h0000ABCD, 1'b0, 0);
    send(1'b0, 32'h0201, 32'h0, 2'b00, 1'b1, 32'hFFFFFFCD, 1'b0, 0);
    send(1'b0, 32'h00010000, 32'h0, 2'b10, 1'b0, 32'h0, 1'b1, 2);
    send(1'b0, 32'h0100, 32'h0, 2'b11, 1'b0, 32'h0, 1'b1, 0);
    send(1'b1, 32'h80000100, 32'h12345678, 2'b10, 1'b0, 32'h0, 1'b1, 0);
    send(1'b0, 32'h0100, 32'h0, 2'b10, 1'b0, 32'hDEADBEEF, 1'b0, 0);
`ifdef LSU_MISALIGN_TRAP_EN
    send(1'b0, 32'h0101, 32'h0, 2'b01, 1'b0, 32'h0, 1'b1, 0);
    send(1'b0, 32'h0102, 32'h0, 2'b10, 1'b0, 32'h0, 1'b1, 0);
    send(1'b1, 32'h0103, 32'hFFFF, 2'b01, 1'b0, 32'h0, 1'b1, 0);
`else
    send(1'b0, 32'h0101, 32'h0, 2'b01, 1'b0, 32'h0000ADBE, 1'b0, 0);
    send(1'b0, 32'h0102, 32'h0, 2'b10, 1'b0, 32'hBEEF0000, 1'b0, 0);
`endif
    drive(1'b1, 32'h0300, 32'h55, 2'b10, 1'b0);
    chk("issue_mem_en", {31'h0, bus.mem_enable}, 32'h1);
    rst = 1'b1; #1;
    chk("rst_issue_mem_en", {31'h0, bus.mem_enable}, 32'h0);
    chk("rst_issue_ready", {31'h0, bus.req_ready}, 32'h0);
    @(posedge clk); #1;
    chk("rst_issue_valid", {31'h0, bus.resp_valid}, 32'h0);
    @(negedge clk); rst = 1'b0; #1;
    chk("rst_issue_idle", {31'h0, bus.req_ready}, 32'h1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("no_resp_after_rst", {31'h0, bus.resp_valid}, 32'h0);
    end
    send(1'b0, 32'h0300, 32'h0, 2'b10, 1'b0, 32'h0, 1'b0, 0);
    drive(1'b0, 32'h0100, 32'h0, 2'b10, 1'b0);
    @(posedge clk); #1;
    chk("mid_resp_valid", {31'h0, bus.resp_valid}, 32'h1);
    chk("mid_resp_rdata", bus.resp_rdata, 32'hDEADBEEF);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_resp_valid", {31'h0, bus.resp_valid}, 32'h0);
    chk("rst_resp_rdata", bus.resp_rdata, 32'h0);
    chk("rst_resp_mem_addr", bus.mem_addr, 32'h0);
    @(negedge clk); rst = 1'b0; #1;
    chk("rst_resp_idle", {31'h0, bus.req_ready}, 32'h1);
    send(1'b0, 32'h0010, 32'h0, 2'b00, 1'b1, 32'hFFFFFF80, 1'b0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
